// File: rtl/queue_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : queue_sensor_conditioner
// Purpose  : Conditions the raw back (entry) and front (exit) photo-beam
//            sensors for the bank queue manager. Each channel synchronises
//            its raw input, debounces it and tracks break/release with a
//            small FSM. One single-cycle event pulse is emitted for each
//            confirmed person passage, on the confirmed release.
// Ports    : clk          - system clock
//            reset        - asynchronous, active-high reset
//            back_raw     - raw back (entry) sensor, asynchronous to clk
//            front_raw    - raw front (exit) sensor, asynchronous to clk
//            enter_evt    - one-cycle pulse, one person passed back sensor
//            exit_evt     - one-cycle pulse, one person passed front sensor
//            back_busy    - back beam confirmed broken
//            front_busy   - front beam confirmed broken
//            back_stuck   - back channel stuck fault
//            front_stuck  - front channel stuck fault
// Options  : define SENSOR_STUCK_DETECT_EN to build the stuck-beam detector;
//            otherwise the stuck outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module queue_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int STUCK_CYCLES       = 1000,
  parameter int SENSOR_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic back_raw,
  input  logic front_raw,
  output logic enter_evt,
  output logic exit_evt,
  output logic back_busy,
  output logic front_busy,
  output logic back_stuck,
  output logic front_stuck
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw level that means "beam clear"; synchroniser flops reset to it.
  localparam logic IDLE_LVL = (SENSOR_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_CLEAR     = 2'd0,
    S_ARMING    = 2'd1,
    S_BLOCKED   = 2'd2,
    S_RELEASING = 2'd3
  } state_e;

  logic [1:0] raw_w;
  logic [1:0] evt_w;
  logic [1:0] busy_w;
  logic [1:0] stuck_w;

  assign raw_w = {front_raw, back_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic          sync1_q, sync2_q;
    logic          b;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          evt_q, evt_d;
    logic          busy_q, busy_d;
    logic          stuck;

    // Two-flop synchroniser; flops rest at the beam-clear level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= IDLE_LVL;
        sync2_q <= IDLE_LVL;
      end else begin
        sync1_q <= raw_w[g];
        sync2_q <= sync1_q;
      end
    end

    // Normalise to "broken" regardless of sensor polarity.
    assign b = sync2_q ^ IDLE_LVL;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= S_CLEAR;
        cnt_q   <= '0;
        evt_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        evt_q   <= evt_d;
        busy_q  <= busy_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (b) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = S_BLOCKED;
              cnt_d   = '0;
            end else begin
              state_d = S_ARMING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_ARMING: begin
          if (!b) begin
            // Break shorter than the debounce window: glitch.
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_BLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_BLOCKED: begin
          if (!b) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = S_CLEAR;
              cnt_d   = '0;
              evt_d   = ~stuck;
            end else begin
              state_d = S_RELEASING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_RELEASING: begin
          if (b) begin
            // Dropout shorter than the debounce window: still blocked.
            state_d = S_BLOCKED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            // A release that ends a stuck episode is an obstruction clearing.
            evt_d   = ~stuck;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      endcase
      busy_d = (state_d == S_BLOCKED) || (state_d == S_RELEASING);
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic [SW-1:0] stuck_inc;
    logic          stuck_q, stuck_d;

    // Saturating increment of the blocked-time counter.
    assign stuck_inc = (stuck_cnt_q == STUCK_MAX) ? stuck_cnt_q
                                                  : stuck_cnt_q + SW'(1);

    always_comb begin
      stuck_cnt_d = stuck_cnt_q;
      stuck_d     = stuck_q;
      if (state_d == S_CLEAR) begin
        stuck_cnt_d = '0;
        stuck_d     = 1'b0;
      end else if ((state_q == S_BLOCKED) || (state_q == S_RELEASING)) begin
        stuck_cnt_d = stuck_inc;
        stuck_d     = stuck_q | (stuck_inc == STUCK_MAX);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stuck_cnt_q <= '0;
        stuck_q     <= 1'b0;
      end else begin
        stuck_cnt_q <= stuck_cnt_d;
        stuck_q     <= stuck_d;
      end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

    assign evt_w[g]   = evt_q;
    assign busy_w[g]  = busy_q;
    assign stuck_w[g] = stuck;
  end

  assign enter_evt   = evt_w[0];
  assign exit_evt    = evt_w[1];
  assign back_busy   = busy_w[0];
  assign front_busy  = busy_w[1];
  assign back_stuck  = stuck_w[0];
  assign front_stuck = stuck_w[1];

endmodule
`default_nettype wire

// File: tb/tb_queue_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_sensor_conditioner
// Purpose  : Self-checking bench for queue_sensor_conditioner
//            (DEBOUNCE_CYCLES=4, STUCK_CYCLES=50, active-high sensors).
//            Expected event cycles are queued when a release is driven and
//            matched when the DUT pulses. Honours SENSOR_STUCK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_sensor_conditioner;

  localparam int DEB = 4;
  localparam int LAT = DEB + 2;
  localparam int STK = 50;
`ifdef SENSOR_STUCK_DETECT_EN
  localparam int STUCK_EN = 1;
`else
  localparam int STUCK_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic back_raw = 1'b0;
  logic front_raw = 1'b0;
  logic enter_evt, exit_evt, back_busy, front_busy, back_stuck, front_stuck;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit done = 1'b0;
  int enter_q[$];
  int exit_q[$];

  queue_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES(STK),
    .SENSOR_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .back_raw(back_raw),
    .front_raw(front_raw),
    .enter_evt(enter_evt),
    .exit_evt(exit_evt),
    .back_busy(back_busy),
    .front_busy(front_busy),
    .back_stuck(back_stuck),
    .front_stuck(front_stuck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the oldest queued expected cycle.
  always @(negedge clk) begin
    if (!done) begin
      if (enter_evt === 1'b1) begin
        if (enter_q.size() == 0) chk("enter_unexpected", cyc, -1);
        else chk("enter_cycle", cyc, enter_q.pop_front());
      end
      if (exit_evt === 1'b1) begin
        if (exit_q.size() == 0) chk("exit_unexpected", cyc, -1);
        else chk("exit_cycle", cyc, exit_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    logic [5:0] outs;

    // Reset and idle
    repeat (3) @(negedge clk);
    outs = {enter_evt, exit_evt, back_busy, front_busy, back_stuck, front_stuck};
    chk("outs_in_reset", outs, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      outs = {enter_evt, exit_evt, back_busy, front_busy, back_stuck, front_stuck};
      chk("outs_idle", outs, 0);
    end

    // Back break 10 cycles then release
    m = cyc;
    back_raw = 1'b1;
    wait_cyc(m + LAT - 1);
    chk("back_busy_early", back_busy, 0);
    wait_cyc(m + LAT);
    chk("back_busy_rise", back_busy, 1);
    wait_cyc(m + 10);
    back_raw = 1'b0;
    enter_q.push_back(m + 10 + LAT);
    wait_cyc(m + 10 + LAT - 1);
    chk("back_busy_hold", back_busy, 1);
    wait_cyc(m + 10 + LAT);
    chk("back_busy_fall", back_busy, 0);
    wait_cyc(m + 25);

    // Front glitch of 2 cycles: ignored
    m = cyc;
    front_raw = 1'b1;
    wait_cyc(m + 2);
    front_raw = 1'b0;
    wait_cyc(m + 12);
    chk("front_busy_glitch", front_busy, 0);

    // Front 20-cycle break with a 2-cycle dropout
    m = cyc;
    front_raw = 1'b1;
    wait_cyc(m + 8);
    front_raw = 1'b0;
    wait_cyc(m + 10);
    front_raw = 1'b1;
    wait_cyc(m + 16);
    chk("front_busy_dropout", front_busy, 1);
    wait_cyc(m + 20);
    front_raw = 1'b0;
    exit_q.push_back(m + 20 + LAT);
    wait_cyc(m + 35);

    // Simultaneous release on both channels
    m = cyc;
    back_raw = 1'b1;
    front_raw = 1'b1;
    wait_cyc(m + 10);
    chk("both_busy", {back_busy, front_busy}, 3);
    back_raw = 1'b0;
    front_raw = 1'b0;
    enter_q.push_back(m + 10 + LAT);
    exit_q.push_back(m + 10 + LAT);
    wait_cyc(m + 25);

    // Reset mid-operation, front still broken through deassertion
    m = cyc;
    back_raw = 1'b1;
    front_raw = 1'b1;
    wait_cyc(m + 8);
    reset = 1'b1;
    back_raw = 1'b0;
    #1;
    chk("busy_after_reset", {back_busy, front_busy}, 0);
    wait_cyc(m + 11);
    reset = 1'b0;
    m = cyc;
    wait_cyc(m + LAT - 1);
    chk("front_busy_post_rst_early", front_busy, 0);
    wait_cyc(m + LAT);
    chk("front_busy_post_rst", front_busy, 1);
    wait_cyc(m + 30);
    front_raw = 1'b0;
    exit_q.push_back(m + 30 + LAT);
    wait_cyc(m + 45);

    // Long back break: stuck behaviour
    m = cyc;
    back_raw = 1'b1;
    wait_cyc(m + LAT + STK - 1);
    chk("back_stuck_before", back_stuck, 0);
    wait_cyc(m + LAT + STK);
    chk("back_stuck_set", back_stuck, STUCK_EN);
    wait_cyc(m + 60);
    back_raw = 1'b0;
    if (STUCK_EN == 0) enter_q.push_back(m + 60 + LAT);
    wait_cyc(m + 60 + LAT - 1);
    chk("back_stuck_hold", back_stuck, STUCK_EN);
    wait_cyc(m + 60 + LAT);
    chk("back_stuck_clear", back_stuck, 0);
    chk("front_stuck_idle", front_stuck, 0);
    wait_cyc(m + 90);

    done = 1'b1;
    chk("enter_pending", enter_q.size(), 0);
    chk("exit_pending", exit_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/queue_sensor_conditioner.md
Name: queue_sensor_conditioner

Overview:
- Upstream stage of the bank queue manager. Conditions the raw back (entry) and front (exit) photo-beam sensors.
- Per channel: synchronises the raw input, debounces it and tracks each beam-break/release with a small FSM.
- Emits exactly one single-cycle event pulse per confirmed person passage: enter_evt from the back sensor, exit_evt from the front sensor.
- The queue counter consumes these pulses directly instead of edge-triggering on raw sensor lines.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to confirm a beam state change; legal range >=1.
- STUCK_CYCLES, 1000: consecutive cycles a beam may remain broken before the channel is declared stuck; legal range > DEBOUNCE_CYCLES.
- SENSOR_ACTIVE_HIGH, 1: 1 means raw input high = beam broken; 0 means raw low = beam broken.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- back_raw  input  1  raw back (entry) sensor, asynchronous to clk
- front_raw  input  1  raw front (exit) sensor, asynchronous to clk
- enter_evt  output  1  one-cycle pulse: one person passed the back sensor
- exit_evt  output  1  one-cycle pulse: one person passed the front sensor
- back_busy  output  1  back beam confirmed broken (state BLOCKED or RELEASING)
- front_busy  output  1  front beam confirmed broken
- back_stuck  output  1  back channel stuck fault
- front_stuck  output  1  front channel stuck fault

Behaviour:
- Two identical, fully independent channels. All outputs are registered.
- Reset values: all outputs 0; FSM = CLEAR; counters = 0; synchroniser flops = beam-clear level.
- Synchroniser: 2-flop per raw input, then normalised to "broken" (b = 1 when beam broken) per SENSOR_ACTIVE_HIGH.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). Stuck counter width: $clog2(STUCK_CYCLES+1); saturates.
- FSM per channel (evaluated each posedge on b):
  - CLEAR: b=1 -> ARMING, cnt=1 (if DEBOUNCE_CYCLES==1, go directly to BLOCKED).
  - ARMING: b=1 -> cnt++; when cnt reaches DEBOUNCE_CYCLES -> BLOCKED. b=0 -> CLEAR, no event (glitch rejected).
  - BLOCKED: b=0 -> RELEASING, cnt=1 (if DEBOUNCE_CYCLES==1, go directly to CLEAR and fire event).
  - RELEASING: b=0 -> cnt++; when cnt reaches DEBOUNCE_CYCLES -> CLEAR and fire event. b=1 -> BLOCKED, no event.
- Event fires on confirmed release only; the break alone never produces a pulse.
- Event pulse is high for exactly one cycle.
- Latency: raw release (stable) to event pulse = DEBOUNCE_CYCLES+2 clk edges. Same latency from raw break to busy=1.
- busy = 1 in BLOCKED and RELEASING, 0 otherwise.
- enter_evt and exit_evt may assert in the same cycle; no arbitration here, downstream handles both.
- Reset mid-operation: everything returns to CLEAR immediately; no pulse is generated by the reset.
- Beam already broken when reset deasserts: channel debounces into BLOCKED with no pulse; one pulse fires on the later release.
- Raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles, in either direction: ignored.

Optional Feature:
- Macro: SENSOR_STUCK_DETECT_EN.
- Defined:
  - Stuck counter runs while the channel is in BLOCKED or RELEASING; it is cleared on entry to CLEAR.
  - When it reaches STUCK_CYCLES, stuck = 1.
  - stuck stays set until the channel returns to CLEAR.
  - The release that ends a stuck episode does NOT fire an event (obstruction, not a person).
- Undefined: stuck counters are not built; back_stuck and front_stuck are tied 0; every confirmed release fires an event.

Test Plan:
- Reset, both raw clear, run 20 cycles -> all outputs 0.
- back_raw high 10 cycles then low, DEBOUNCE_CYCLES=4 -> back_busy rises 6 edges after the break; exactly one enter_evt pulse 6 edges after the release; exit_evt stays 0.
- front_raw glitch high for 2 cycles, and a 2-cycle low dropout during a 20-cycle break -> no extra events; exactly one exit_evt after the final release.
- back_raw and front_raw released on the same edge -> enter_evt and exit_evt high together for one cycle.
- front_raw held broken through reset deassertion, released after 30 cycles -> no pulse at reset; one exit_evt at release.
- Macro defined, STUCK_CYCLES=50: back_raw broken 60 cycles -> back_stuck=1 at cycle 50 of BLOCKED/RELEASING; on release, back_stuck clears with no enter_evt. Macro undefined: same stimulus gives back_stuck=0 and one enter_evt.
